ch_seq: RTL

- Per-channel sequencer for one DMA channel datapath: the src FIFO, the processing module, and the dst FIFO.
- Accepts a descriptor from the descriptor engine and clears the channel FIFOs.
- Gates source fetch on the stream engine using the channel's start/stop hints, counts source words, and marks the last one.
- Waits for the module to finish and for the dst FIFO to reach its end marker, then reports completion with the output word count and a status code.

---
 rtl/ch_seq_pkg.sv | 33 +++
 rtl/ch_seq_wdog.sv | 39 +++
 rtl/ch_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ch_seq_pkg.sv
// Shared types and constants for the DMA channel sequencer:
// FSM states, completion status codes and descriptor field positions.
package ch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        FIN   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ZLEN = 2'd1,
        ST_OVR  = 2'd2,
        ST_TO   = 2'd3
    } status_e;

    localparam int DC_LEN_LSB = 0;
    localparam int DC_LEN_MSB = 15;
    localparam int DC_IEN     = 23;

    // Timeout outranks overrun, which outranks zero length.
    function automatic status_e status_pick(input logic to_hit, input logic ovr, input logic zlen);
        if (to_hit)    return ST_TO;
        else if (ovr)  return ST_OVR;
        else if (zlen) return ST_ZLEN;
        else           return ST_OK;
    endfunction

endpackage

// File: rtl/ch_seq_wdog.sv
// Saturating stall watchdog. tc_o rises in the cycle the count reaches its
// all-ones value and holds while saturated.
module ch_seq_wdog #(
    parameter int TO_W = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    import ch_seq_pkg::*;

    localparam logic [TO_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0] CNT_PRE = CNT_MAX - TO_W'(1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_MAX) || (en_i && !clr_i && (cnt_q == CNT_PRE));

endmodule

// File: rtl/ch_seq.sv
// Per-channel DMA sequencer: clears the channel FIFOs, gates source fetch,
// counts source words and reports completion with output count and status.
//
// state | meaning
// IDLE  | waiting for a descriptor (go)
// CLEAR | m_reset pulse to FIFOs and module, 2 cycles
// FEED  | source words being fetched and counted
// WAIT  | all source words in, waiting for module end (m_endn low)
// DRAIN | waiting for the dst FIFO end marker
// FIN   | one-cycle done pulse, status/out_cnt valid
module ch_seq #(
    parameter int LEN_W = 16,
    parameter int TO_W  = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        go,
    input  logic [23:0] dc,
    output logic        busy,
    output logic        m_reset,
    output logic        fetch_en,
    input  logic        ss_xfer,
    output logic        ss_last,
    input  logic        ss_start,
    input  logic        ss_stop,
    input  logic        m_endn,
    input  logic        ss_end,
    input  logic [15:0] ocnt,
    output logic        done,
    output logic        irq,
    output logic [1:0]  status,
    output logic [15:0] out_cnt
);
    import ch_seq_pkg::*;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ien_q, ien_d;
    logic             zlen_q, zlen_d;
    logic             ovr_q, ovr_d;
    logic             endn_q, endn_d;
    logic             clr_cnt_q, clr_cnt_d;
    logic             fetch_q, fetch_d;
    logic             irq_q, irq_d;
    status_e          status_q, status_d;
    logic [15:0]      out_cnt_q, out_cnt_d;
    logic [15:0]      ocnt_q;

    logic             active;
    logic             progress;
    logic             wd_clr, wd_en, wd_tc;
    logic [LEN_W-1:0] dc_len;
    logic             dc_unused;

    assign dc_len    = LEN_W'(dc[DC_LEN_MSB:DC_LEN_LSB]);
    assign dc_unused = ^dc[22:16];

    assign active   = (state_q == FEED) || (state_q == WAIT) || (state_q == DRAIN);
    assign progress = ss_xfer || (ocnt != ocnt_q);
    // DRAIN has no progress signal of its own, so every cycle there counts.
    assign wd_clr   = !active || (progress && (state_q != DRAIN));
    assign wd_en    = ((state_q == FEED) || (state_q == WAIT)) ? !progress : (state_q == DRAIN);

    ch_seq_wdog #(.TO_W(TO_W)) u_wdog (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        ien_d     = ien_q;
        zlen_d    = zlen_q;
        ovr_d     = ovr_q;
        endn_d    = endn_q;
        clr_cnt_d = clr_cnt_q;
        irq_d     = irq_q;
        status_d  = status_q;
        out_cnt_d = out_cnt_q;
        fetch_d   = 1'b0;

        if (active && ss_xfer) begin
            if (rem_q == '0) ovr_d = 1'b1;
            else             rem_d = rem_q - LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    rem_d     = dc_len;
                    ien_d     = dc[DC_IEN];
                    zlen_d    = (dc_len == '0);
                    ovr_d     = 1'b0;
                    endn_d    = 1'b0;
                    clr_cnt_d = 1'b0;
                    irq_d     = 1'b0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                clr_cnt_d = 1'b1;
                if (clr_cnt_q) state_d = zlen_q ? FIN : FEED;
            end
            FEED: begin
                if (!m_endn)        endn_d  = 1'b1;
                if (rem_q == '0)    state_d = WAIT;
            end
            WAIT: begin
                if (!m_endn || endn_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (ss_end) state_d = FIN;
            end
            FIN: begin
                irq_d   = ien_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (active && wd_tc) state_d = FIN;

        if ((state_q == FEED) && (state_d == FEED) && (rem_d != '0) && !ss_stop) begin
            fetch_d = ss_start || fetch_q;
        end

        // Status and count are captured on entry so they are valid alongside done.
        if ((state_d == FIN) && (state_q != FIN)) begin
            status_d  = status_pick(active && wd_tc, ovr_d, zlen_q);
            out_cnt_d = ocnt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            ien_q     <= 1'b0;
            zlen_q    <= 1'b0;
            ovr_q     <= 1'b0;
            endn_q    <= 1'b0;
            clr_cnt_q <= 1'b0;
            fetch_q   <= 1'b0;
            irq_q     <= 1'b0;
            status_q  <= ST_OK;
            out_cnt_q <= '0;
            ocnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            ien_q     <= ien_d;
            zlen_q    <= zlen_d;
            ovr_q     <= ovr_d;
            endn_q    <= endn_d;
            clr_cnt_q <= clr_cnt_d;
            fetch_q   <= fetch_d;
            irq_q     <= irq_d;
            status_q  <= status_d;
            out_cnt_q <= out_cnt_d;
            ocnt_q    <= ocnt;
        end
    end

    assign busy     = (state_q != IDLE);
    assign m_reset  = (state_q == CLEAR);
    assign fetch_en = fetch_q;
    assign ss_last  = (state_q == FEED) && (rem_q == LEN_W'(1));
    assign done     = (state_q == FIN);
    assign irq      = irq_q;
    assign status   = status_q;
    assign out_cnt  = out_cnt_q;

endmodule
